// File: rtl/aes128_key_expander_if.sv
// Handshake and read port between the key expander and the cipher stage.
interface aes128_key_expander_if;
    logic         start;
    logic [127:0] key;
    logic         busy;
    logic         done;
    logic         valid;
    logic [3:0]   rk_addr;
    logic [127:0] rk_data;

    modport master (
        output start, key, rk_addr,
        input  busy, done, valid, rk_data
    );

    modport slave (
        input  start, key, rk_addr,
        output busy, done, valid, rk_data
    );
endinterface

// File: rtl/aes128_key_expander.sv
// AES-128 key schedule: one round key per clock into an 11-entry table,
// with a combinational random-access read port for the cipher stage.

// Forward AES byte S-box, shared with the aes128 SubBytes stage.
module aes128_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);
    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign dout = SBOX[din];
endmodule

module aes128_key_expander (
    input  logic                   clk,
    input  logic                   rst,
    aes128_key_expander_if.slave   kx
);
    localparam int NUM_RK = 11;

    typedef enum logic {IDLE, EXPAND} state_t;

    state_t       state, state_nxt;
    logic [3:0]   rnd;
    logic [127:0] rk_tbl [0:NUM_RK-1];
    logic [127:0] cur_rk;           // last key written; avoids a table read in the round path
    logic [127:0] nxt_rk;
    logic         done_q, valid_q;
    logic         busy_c, accept, last;
    logic [7:0]   rcon;
    logic [31:0]  rot_w, sub_w, t_w;
    logic [31:0]  w0, w1, w2, w3;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state: leave IDLE on start, return after the rk10 write
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (kx.start)    state_nxt = EXPAND;
            EXPAND:  if (rnd == 4'd10) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy_c = (state == EXPAND);
        accept = (state == IDLE) && kx.start;
        last   = (state == EXPAND) && (rnd == 4'd10);
    end

    // Round constant lookup by round number
    always_comb begin
        rcon = 8'h00;
        case (rnd)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    // One round of the schedule: SubWord(RotWord(w3)) ^ Rcon, then XOR chain
    assign rot_w = {cur_rk[23:0], cur_rk[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes128_sbox u_sbox (
            .din  (rot_w[8*g +: 8]),
            .dout (sub_w[8*g +: 8])
        );
    end

    assign t_w    = sub_w ^ {rcon, 24'h0};
    assign w0     = cur_rk[127:96] ^ t_w;
    assign w1     = cur_rk[95:64]  ^ w0;
    assign w2     = cur_rk[63:32]  ^ w1;
    assign w3     = cur_rk[31:0]   ^ w2;
    assign nxt_rk = {w0, w1, w2, w3};

    // Table, round counter and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            rnd     <= 4'd0;
            cur_rk  <= '0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            for (int i = 0; i < NUM_RK; i++) rk_tbl[i] <= '0;
        end else begin
            done_q <= last;
            if (accept) begin
                rk_tbl[0] <= kx.key;
                cur_rk    <= kx.key;
                rnd       <= 4'd1;
                valid_q   <= 1'b0;
            end else if (busy_c) begin
                rk_tbl[rnd] <= nxt_rk;
                cur_rk      <= nxt_rk;
                if (last) begin
                    rnd     <= 4'd0;
                    valid_q <= 1'b1;
                end else begin
                    rnd <= rnd + 4'd1;
                end
            end
        end
    end

    assign kx.busy    = busy_c;
    assign kx.done    = done_q;
    assign kx.valid   = valid_q;
    assign kx.rk_data = (kx.rk_addr <= 4'd10) ? rk_tbl[kx.rk_addr] : '0;
endmodule

// File: tb/tb_aes128_key_expander.sv
// Randomized and directed check of aes128_key_expander against a FIPS-197
// style word-schedule model with an arithmetically derived S-box.
module tb_aes128_key_expander;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nchk = 0;
    int   nerr = 0;

    logic [7:0]   sbox_m [0:255];
    logic [127:0] ref_rk [0:10];

    aes128_key_expander_if kx ();

    aes128_key_expander dut (
        .clk (clk),
        .rst (rst),
        .kx  (kx)
    );

    always #5 clk = ~clk;

    // Single comparison point
    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from GF(2^8) inverse followed by the affine map
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] xb  = 8'(x);
            logic [7:0] inv = 8'h01;
            if (x == 0) inv = 8'h00;
            else for (int k = 0; k < 254; k++) inv = gmul(inv, xb);
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Word-oriented key expansion into 44 words, regrouped as 11 round keys
    task automatic model(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] tmp;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_m[tmp[31:24]], sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]]};
                tmp ^= {rc, 24'h0};
                rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] rnd_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Drive start for one edge; returns at accept edge + 1
    task automatic start_key(input logic [127:0] k);
        kx.key   = k;
        kx.start = 1'b1;
        @(posedge clk); #1;
        kx.start = 1'b0;
    endtask

    // Wait for done; e0 = edges already elapsed counting the accept edge
    task automatic wait_done(input int e0);
        int e = e0;
        while (!kx.done && e < 30) begin
            chk("busy_exp", 128'(kx.busy), 128'd1);
            @(posedge clk); #1;
            e++;
        end
        chk("done_lat", 128'(e), 128'd11);
        chk("busy_end", 128'(kx.busy), 128'd0);
        chk("valid_end", 128'(kx.valid), 128'd1);
    endtask

    task automatic check_table(input logic [127:0] k);
        model(k);
        for (int a = 0; a < 11; a++) begin
            kx.rk_addr = 4'(a);
            #1;
            chk($sformatf("rk%0d", a), kx.rk_data, ref_rk[a]);
        end
    endtask

    task automatic read_rk(input int a, output logic [127:0] d);
        kx.rk_addr = 4'(a);
        #1;
        d = kx.rk_data;
    endtask

    task automatic full_run(input logic [127:0] k);
        start_key(k);
        chk("acc_busy", 128'(kx.busy), 128'd1);
        chk("acc_valid", 128'(kx.valid), 128'd0);
        wait_done(1);
        check_table(k);
    endtask

    initial begin
        logic [127:0] d;
        logic [127:0] ka, kb, kc;

        kx.start   = 1'b0;
        kx.key     = '0;
        kx.rk_addr = 4'd0;
        build_sbox();

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_busy", 128'(kx.busy), 128'd0);
        chk("rst_done", 128'(kx.done), 128'd0);
        chk("rst_valid", 128'(kx.valid), 128'd0);
        read_rk(0, d);  chk("rst_rk0", d, 128'h0);
        read_rk(10, d); chk("rst_rk10", d, 128'h0);
        @(posedge clk); #1;

        // Known-answer vectors
        full_run(128'h000102030405060708090a0b0c0d0e0f);
        read_rk(10, d); chk("kat1_rk10", d, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        full_run(128'h2b7e151628aed2a6abf7158809cf4f3c);
        read_rk(1, d);  chk("kat2_rk1", d, 128'ha0fafe1788542cb123a339392a6c7605);
        read_rk(10, d); chk("kat2_rk10", d, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        full_run(128'h5468617473206d79204b756e67204675);
        read_rk(1, d);  chk("kat3_rk1", d, 128'he232fcf191129188b159e4e6d679a293);
        read_rk(10, d); chk("kat3_rk10", d, 128'h28fddef86da4244accc0a4fe3b316f26);

        // Random keys
        for (int n = 0; n < 6; n++) full_run(rnd_key());

        // Start and key changes while busy are ignored
        ka = rnd_key();
        kb = rnd_key();
        start_key(ka);
        repeat (3) @(posedge clk);
        #1;
        kx.start = 1'b1;
        kx.key   = kb;
        @(posedge clk); #1;
        kx.start = 1'b0;
        wait_done(5);
        check_table(ka);

        // Reset at E6 aborts and clears the table
        kc = rnd_key();
        start_key(kc);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", 128'(kx.busy), 128'd0);
        chk("abort_valid", 128'(kx.valid), 128'd0);
        read_rk(0, d); chk("abort_rk0", d, 128'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_busy2", 128'(kx.busy), 128'd0);
        chk("abort_valid2", 128'(kx.valid), 128'd0);
        full_run(kc);

        // Reset wins over a simultaneous start
        kx.key   = rnd_key();
        kx.start = 1'b1;
        rst      = 1'b1;
        @(posedge clk); #1;
        kx.start = 1'b0;
        rst      = 1'b0;
        chk("rst_start_busy", 128'(kx.busy), 128'd0);
        @(posedge clk); #1;
        chk("rst_start_busy2", 128'(kx.busy), 128'd0);

        // Start in the done cycle is accepted and drops valid
        ka = rnd_key();
        kb = rnd_key();
        start_key(ka);
        wait_done(1);
        start_key(kb);
        chk("b2b_busy", 128'(kx.busy), 128'd1);
        chk("b2b_valid", 128'(kx.valid), 128'd0);
        chk("b2b_done", 128'(kx.done), 128'd0);
        wait_done(1);
        check_table(kb);

        // Out-of-range addresses read as zero
        read_rk(11, d); chk("addr11", d, 128'h0);
        read_rk(15, d); chk("addr15", d, 128'h0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
